// File: rtl/inst_rom_server.sv
// inst_rom_server: instruction memory on the CPU fetch port, with a byte-serial
// boot loader. Fetches return a registered word one cycle after the address.
// While a load session runs, fetches return NOP (all zeros) because the core
// cannot be stalled. Loader bytes are packed big-endian: the first byte of
// each group of four becomes bits [31:24] of the word.
module inst_rom_server #(
  parameter int ADDR_WIDTH = 10,
  parameter int LOAD_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] romAddr_i,
  output logic [31:0] romData_o,
  input  logic        loadStart_i,
  input  logic [7:0]  loadByte_i,
  input  logic        loadValid_i,
  output logic        loadReady_o,
  output logic        loadDone_o,
  output logic        busy_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Word counter is one bit wider than the index so a full-depth session can
  // reach its last index and compare without wrapping first.
  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH + 1)'(LOAD_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH:0]     word_cnt;
  logic [1:0]              byte_cnt;
  logic [31:0]             asm_reg;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    word_complete;
  logic [31:0]             next_word;
  logic [ADDR_WIDTH-1:0]   fetch_idx;
  logic                    out_of_range;
  logic                    unused_addr_bits;

  // Byte handshake and the word formed by the byte arriving this cycle.
  assign accept        = (state == LOAD) && loadValid_i && loadReady_o;
  assign word_complete = accept && (byte_cnt == 2'd3);
  assign next_word     = {asm_reg[23:0], loadByte_i};

  // Fetch address decode; the byte offset within the word is not used.
  assign fetch_idx        = romAddr_i[ADDR_WIDTH+1:2];
  assign out_of_range     = |romAddr_i[31:ADDR_WIDTH+2];
  assign unused_addr_bits = ^romAddr_i[1:0];

  // Array write: the fourth byte of a word and the three before it land together.
  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (word_complete) begin
      mem[word_cnt[ADDR_WIDTH-1:0]] <= next_word;
    end
  end

  // Registered fetch response: NOP while loading or for addresses past the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      romData_o <= 32'h0000_0000;
    end else if (busy_o || out_of_range) begin
      romData_o <= 32'h0000_0000;
    end else begin
      romData_o <= mem[fetch_idx];
    end
  end

  // Loader FSM with registered handshake and status outputs.
  // NOTE: every state register here uses <= so all reads see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      byte_cnt    <= '0;
      asm_reg     <= '0;
      loadReady_o <= 1'b0;
      loadDone_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          loadDone_o <= 1'b0;
          if (loadStart_i) begin
            state       <= LOAD;
            word_cnt    <= '0;
            byte_cnt    <= '0;
            loadReady_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end

        LOAD: begin
          if (accept) begin
            asm_reg <= next_word;
            if (byte_cnt == 2'd3) begin
              byte_cnt <= '0;
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == LAST_WORD) begin
                state       <= DONE;
                loadReady_o <= 1'b0;
                loadDone_o  <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        DONE: begin
          state      <= IDLE;
          loadDone_o <= 1'b0;
          busy_o     <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          loadReady_o <= 1'b0;
          loadDone_o  <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_server.sv
// Self-checking bench for inst_rom_server. A session-level model (byte queue,
// accepted-byte count, word array with written flags) predicts every output;
// one compare process checks the DUT against it on each falling edge, and a
// few literal values from the directed load pin the model itself.
module tb_inst_rom_server;

  localparam int AW    = 10;
  localparam int LW    = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        load_start;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        busy;

  inst_rom_server #(.ADDR_WIDTH(AW), .LOAD_WORDS(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .romAddr_i  (rom_addr),
    .romData_o  (rom_data),
    .loadStart_i(load_start),
    .loadByte_i (load_byte),
    .loadValid_i(load_valid),
    .loadReady_o(load_ready),
    .loadDone_o (load_done),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  logic [7:0]  pend [$];        // bytes of the word being assembled
  bit          in_session;      // bytes are being accepted
  bit          done_pending;    // the completion cycle
  int          accepted;        // bytes accepted this session
  logic [31:0] exp_data;
  bit          exp_data_known;

  task automatic model_reset();
    in_session     = 1'b0;
    done_pending   = 1'b0;
    accepted       = 0;
    pend.delete();
    exp_data       = 32'h0;
    exp_data_known = 1'b1;
  endtask

  // Advance the model by one rising edge given the inputs seen at that edge.
  task automatic model_step(input bit start, input bit valid, input logic [7:0] b,
                            input logic [31:0] addr);
    int idx;
    int w;
    if (in_session || done_pending) begin
      exp_data = 32'h0; exp_data_known = 1'b1;
    end else if ((addr >> (AW + 2)) != 0) begin
      exp_data = 32'h0; exp_data_known = 1'b1;
    end else begin
      idx            = int'((addr >> 2) & 32'(DEPTH - 1));
      exp_data       = ref_mem[idx];
      exp_data_known = ref_known[idx];
    end

    if (done_pending) begin
      done_pending = 1'b0;
    end else if (in_session) begin
      if (valid) begin
        pend.push_back(b);
        accepted++;
        if (accepted % 4 == 0) begin
          w            = accepted / 4 - 1;
          ref_mem[w]   = {pend[0], pend[1], pend[2], pend[3]};
          ref_known[w] = 1'b1;
          pend.delete();
          if (w == LW - 1) begin
            in_session   = 1'b0;
            done_pending = 1'b1;
          end
        end
      end
    end else if (start) begin
      in_session = 1'b1;
      accepted   = 0;
      pend.delete();
    end
  endtask

  // ---------------- compare process ----------------
  int done_seen = 0;
  always @(negedge clk) begin
    if (exp_data_known) check("rom_data", rom_data, exp_data);
    check("busy",  32'(busy),       32'(in_session || done_pending));
    check("ready", 32'(load_ready), 32'(in_session));
    check("done",  32'(load_done),  32'(done_pending));
    if (load_done === 1'b1) done_seen++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle(input bit start, input bit valid, input logic [7:0] b,
                       input logic [31:0] addr);
    load_start = start;
    load_valid = valid;
    load_byte  = b;
    rom_addr   = addr;
    @(posedge clk);
    model_step(start, valid, b, addr);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      6:       return $urandom | 32'h0000_1000;
      7:       return 32'h0000_1000 + 32'($urandom_range(0, 3) << 2);
      default: return 32'($urandom_range(0, 4 * LW + 3));
    endcase
  endfunction

  task automatic send_bytes(input logic [7:0] bytes [$], input int gap_pct, input bit noise);
    foreach (bytes[i]) begin
      for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
        cycle(noise && ($urandom_range(0, 3) == 0), 1'b0, 8'($urandom), rand_addr());
      end
      cycle(noise && ($urandom_range(0, 3) == 0), 1'b1, bytes[i], rand_addr());
    end
  endtask

  // Assert rst between edges, check outputs before any edge, then release.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy",  32'(busy),       32'h0);
    check("async_rst_ready", 32'(load_ready), 32'h0);
    check("async_rst_done",  32'(load_done),  32'h0);
    check("async_rst_data",  rom_data,        32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, rand_addr());
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] q [$];
    int         done_before;
    int         n;

    rst        = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_byte  = 8'h00;
    rom_addr   = 32'h0;
    model_reset();
    #2;
    check("reset_data",  rom_data,         32'h0);
    check("reset_busy",  32'(busy),        32'h0);
    check("reset_ready", 32'(load_ready),  32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Directed two-word load, no gaps.
    cycle(1'b1, 1'b0, 8'h00, 32'h0);
    check("start_ready", 32'(load_ready), 32'h1);
    check("start_busy",  32'(busy),       32'h1);
    done_before = done_seen;
    q = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h24, 8'h03, 8'h00, 8'h07};
    send_bytes(q, 0, 1'b0);
    check("done_after_8th", 32'(load_done), 32'h1);
    check("done_busy",      32'(busy),      32'h1);
    cycle(1'b0, 1'b0, 8'h00, 32'h0);
    check("done_clears",    32'(load_done), 32'h0);
    check("busy_falls",     32'(busy),      32'h0);
    check("done_count",     32'(done_seen - done_before), 32'h1);
    cycle(1'b0, 1'b0, 8'h00, 32'h0);
    check("fetch_0", rom_data, 32'h2402_0005);
    cycle(1'b0, 1'b0, 8'h00, 32'h4);
    check("fetch_4", rom_data, 32'h2403_0007);
    cycle(1'b0, 1'b0, 8'h00, 32'h6);
    check("fetch_6", rom_data, 32'h2403_0007);
    cycle(1'b0, 1'b0, 8'h00, 32'h0000_1000);
    check("fetch_oor", rom_data, 32'h0);

    // Stalled load with start pulses during LOAD; NOP while busy.
    cycle(1'b1, 1'b0, 8'h00, 32'h0);
    cycle(1'b0, 1'b0, 8'h00, 32'h0);
    check("nop_busy", rom_data, 32'h0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_bytes(q, 60, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 8'h00, 32'h0);
    check("stall_fetch_0", rom_data, 32'h1122_3344);
    cycle(1'b0, 1'b0, 8'h00, 32'h4);
    check("stall_fetch_4", rom_data, 32'h5566_7788);

    // Reset two bytes into word 1: word 0 kept, word 1 untouched.
    cycle(1'b1, 1'b0, 8'h00, 32'h0);
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    send_bytes(q, 20, 1'b0);
    async_reset();
    idle(1);
    cycle(1'b0, 1'b0, 8'h00, 32'h0);
    check("abort_keep_0", rom_data, 32'hAABB_CCDD);
    cycle(1'b0, 1'b0, 8'h00, 32'h4);
    check("abort_keep_1", rom_data, 32'h5566_7788);
    cycle(1'b1, 1'b0, 8'h00, 32'h0);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_bytes(q, 30, 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, 8'h00, 32'h0);
    check("fresh_fetch_0", rom_data, 32'h0102_0304);
    cycle(1'b0, 1'b0, 8'h00, 32'h4);
    check("fresh_fetch_1", rom_data, 32'h0506_0708);

    // Randomized sessions, some aborted by reset part-way.
    for (int s = 0; s < 30; s++) begin
      idle($urandom_range(0, 4));
      q.delete();
      for (int k = 0; k < 4 * LW; k++) q.push_back(8'($urandom));
      cycle(1'b1, 1'b0, 8'h00, rand_addr());
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(0, 4 * LW - 1);
        while (q.size() > n) void'(q.pop_back());
        send_bytes(q, 30, 1'b1);
        async_reset();
      end else begin
        send_bytes(q, 30, 1'b1);
      end
      idle($urandom_range(3, 8));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_rom_server.md
Name: inst_rom_server

Overview:
- Instruction-memory responder sitting on the CPU fetch interface. It answers the core's 32-bit fetch address with a registered instruction word.
- It contains a byte-serial boot loader that fills the word array before execution starts.
- The core has no stall input, so while a load is in progress this block feeds it NOPs (32'h0000_0000).

Parameters:
- ADDR_WIDTH, 10, log2 of array depth in words (1024 words = 4 KiB).
- LOAD_WORDS, 1024, number of words written per load session (1..2^ADDR_WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- romAddr_i  input  32  byte fetch address from the CPU pc.
- romData_o  output  32  instruction word returned to the CPU.
- loadStart_i  input  1  begins a load session; sampled only in IDLE.
- loadByte_i  input  8  loader data byte.
- loadValid_i  input  1  loadByte_i is valid this cycle.
- loadReady_o  output  1  block accepts a byte this cycle.
- loadDone_o  output  1  one-cycle pulse when a session completes.
- busy_o  output  1  load session in progress; fetches return NOP.

Behaviour:
- Reset (asynchronous, active-high, applies immediately):
  - romData_o = 0; state = IDLE; wordCnt = 0; byteCnt = 0; assembly register = 0.
  - loadReady_o = 0; loadDone_o = 0; busy_o = 0.
  - Array contents are NOT reset.
- Fetch path:
  - Word index = romAddr_i[ADDR_WIDTH+1:2]. romAddr_i[1:0] is ignored.
  - Latency is 1 cycle: romData_o is registered at the edge after the address is presented.
  - If romAddr_i[31:ADDR_WIDTH+2] != 0 (out of range), romData_o = 0 the next cycle.
  - While busy_o = 1, romData_o is registered as 0 regardless of address.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: loadReady_o = 0, busy_o = 0. On loadStart_i = 1, go to LOAD and clear wordCnt and byteCnt.
  - LOAD: loadReady_o = 1, busy_o = 1.
    - A byte is accepted when loadValid_i & loadReady_o.
    - On acceptance, asm <= {asm[23:0], loadByte_i}. Assembly is big-endian: the first byte becomes bits [31:24].
    - On the 4th accepted byte (byteCnt == 3): write {asm[23:0], loadByte_i} to mem[wordCnt] in the same edge, set byteCnt = 0, increment wordCnt.
    - If that written word was wordCnt == LOAD_WORDS-1, go to DONE. Otherwise remain in LOAD.
    - loadValid_i = 0 causes no change (stall).
    - loadStart_i is ignored in LOAD.
  - DONE: loadReady_o = 0, busy_o = 1, loadDone_o = 1 for exactly this cycle; then go to IDLE.
- Timing: romData_o reflects new contents on the first fetch edge after busy_o falls. The first valid fetch output appears 1 cycle after IDLE is re-entered.
- Counters: wordCnt is ADDR_WIDTH+1 bits wide so LOAD_WORDS = 2^ADDR_WIDTH does not wrap before the compare. byteCnt is 2 bits.
- Reset mid-LOAD: the session aborts. Words already written remain; the partial word is discarded.
- Simultaneous loadStart_i and rst: rst wins.
- LOAD_WORDS = 1: the session completes after 4 bytes.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> romData_o = 0, busy_o = 0, loadReady_o = 0 immediately, without waiting for a clock edge.
- Load 2 words with LOAD_WORDS = 2: bytes 24,02,00,05, 24,03,00,07 -> mem[0] = 32'h2402_0005, mem[1] = 32'h2403_0007. loadDone_o pulses once, the cycle after the 8th byte. busy_o then falls.
- Fetch after load: romAddr_i = 0 then 4 on consecutive cycles -> romData_o = 32'h2402_0005, then 32'h2403_0007, each one cycle later. romAddr_i = 6 -> 32'h2403_0007 (low bits ignored). romAddr_i = 32'h0000_1000 -> 0 (out of range).
- Loader stall: insert loadValid_i = 0 gaps between bytes -> identical array contents; loadReady_o stays 1 throughout LOAD.
- NOP during busy: present romAddr_i = 0 while busy_o = 1 -> romData_o = 0 every cycle. loadStart_i pulses during LOAD -> no restart; wordCnt is unchanged.
- Reset mid-word: after 2 bytes of word 1, assert rst -> IDLE; mem[0] is retained and mem[1] is unchanged. A fresh session then loads correctly.
